ps2_dev_tx: RTL

//  Parametrised PS/2 device-side transmitter: generalised successor to the fixed keyboard shift-register stub.

---
 rtl/ps2_dev_tx_pkg.sv | 23 ++
 rtl/ps2_dev_tx_if.sv | 23 ++
 rtl/ps2_dev_tx_fifo.sv | 43 ++++
 rtl/ps2_dev_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ps2_dev_tx_pkg.sv
// Shared types and frame helpers for the PS/2 device-side transmitter.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_GAP
  } ps2_tx_state_t;

  function automatic logic ps2_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // Bit 0 goes on the wire first: start, data LSB-first, parity, stop.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data, input logic odd);
    return {1'b1, ps2_parity(data, odd), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_dev_tx_if.sv
// Byte-write, host-inhibit and PS/2 line bundle between a byte source and the transmitter.
interface ps2_dev_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       host_inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       frame_done;
  logic       overflow;

  modport master (
    output wr_en, wr_data, host_inhibit,
    input  ps2_clk, ps2_data, full, empty, busy, frame_done, overflow
  );

  modport slave (
    input  wr_en, wr_data, host_inhibit,
    output ps2_clk, ps2_data, full, empty, busy, frame_done, overflow
  );
endinterface

// File: rtl/ps2_dev_tx_fifo.sv
// Synchronous byte FIFO with show-ahead head; a push while full is accepted only alongside a pop.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop     = i_rd_en && !o_empty;
  assign w_push    = i_wr_en && (!o_full || w_pop);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device transmitter: FIFO-buffered bytes serialised as 11-bit frames on self-driven clock/data lines.
//  state  | meaning
//  IDLE   | lines high, waiting for a byte and no inhibit
//  SETUP  | put the current frame bit on ps2_data
//  CLK_HI | hold ps2_clk high CLK_DIV cycles
//  CLK_LO | hold ps2_clk low CLK_DIV cycles (host samples on the fall)
//  GAP    | lines high GAP_CYC cycles after a frame or an abort
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ODD_PARITY = 1,
  parameter int GAP_CYC    = 16
) (
  input  logic        i_kbd_clk,
  input  logic        i_rst_n,
  ps2_dev_tx_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  ps2_tx_state_t    r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [3:0]       r_bit_idx;
  logic [7:0]       r_tx_byte;
  logic             r_retry_vld;
  logic             r_ps2_clk;
  logic             r_ps2_data;
  logic             r_frame_done;
  logic             r_overflow;

  ps2_tx_state_t    w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [3:0]       w_bit_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_retry_nxt;
  logic             w_clk_nxt;
  logic             w_data_nxt;
  logic             w_done_nxt;
  logic             w_pop;
  logic             w_abort;
  logic             w_has_byte;
  logic [7:0]       w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [PS2_FRAME_BITS-1:0] w_frame;

  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_kbd_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.wr_en),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // An aborted byte stays in r_tx_byte and acts as the FIFO head until resent.
  assign w_has_byte = r_retry_vld || !w_fifo_empty;
  assign w_frame    = ps2_frame(r_tx_byte, ODD_BIT);
  assign w_abort    = bus.host_inhibit && (r_bit_idx <= 4'd9) &&
                      ((r_state == ST_SETUP) || (r_state == ST_CLK_HI) || (r_state == ST_CLK_LO));

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_tx_byte;
    w_retry_nxt = r_retry_vld;
    w_clk_nxt   = r_ps2_clk;
    w_data_nxt  = r_ps2_data;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_GAP;
      w_clk_nxt   = 1'b1;
      w_data_nxt  = 1'b1;
      w_retry_nxt = 1'b1;
      w_gap_nxt   = GAP_LOAD;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_clk_nxt  = 1'b1;
          w_data_nxt = 1'b1;
          if (w_has_byte && !bus.host_inhibit) begin
            if (!r_retry_vld) begin
              w_byte_nxt = w_fifo_head;
              w_pop      = 1'b1;
            end
            w_retry_nxt = 1'b0;
            w_bit_nxt   = 4'd0;
            w_state_nxt = ST_SETUP;
          end
        end
        ST_SETUP: begin
          w_data_nxt  = w_frame[r_bit_idx];
          w_div_nxt   = DIV_LOAD;
          w_state_nxt = ST_CLK_HI;
        end
        ST_CLK_HI: begin
          if (r_div_cnt == '0) begin
            w_clk_nxt   = 1'b0;
            w_div_nxt   = DIV_LOAD;
            w_state_nxt = ST_CLK_LO;
          end else begin
            w_div_nxt = r_div_cnt - DIV_W'(1);
          end
        end
        ST_CLK_LO: begin
          if (r_div_cnt == '0) begin
            w_clk_nxt = 1'b1;
            if (r_bit_idx == 4'd10) begin
              w_done_nxt  = 1'b1;
              w_data_nxt  = 1'b1;
              w_gap_nxt   = GAP_LOAD;
              w_state_nxt = ST_GAP;
            end else begin
              w_bit_nxt   = r_bit_idx + 4'd1;
              w_state_nxt = ST_SETUP;
            end
          end else begin
            w_div_nxt = r_div_cnt - DIV_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
          else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_kbd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_div_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_bit_idx    <= '0;
      r_tx_byte    <= '0;
      r_retry_vld  <= 1'b0;
      r_ps2_clk    <= 1'b1;
      r_ps2_data   <= 1'b1;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div_cnt    <= w_div_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_tx_byte    <= w_byte_nxt;
      r_retry_vld  <= w_retry_nxt;
      r_ps2_clk    <= w_clk_nxt;
      r_ps2_data   <= w_data_nxt;
      r_frame_done <= w_done_nxt;
      r_overflow   <= bus.wr_en && w_fifo_full && !w_pop;
    end
  end

  assign bus.ps2_clk    = r_ps2_clk;
  assign bus.ps2_data   = r_ps2_data;
  assign bus.full       = w_fifo_full;
  assign bus.empty      = w_fifo_empty && !r_retry_vld;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;

endmodule
